alu_mdu: RTL and testbench

Execute-stage arithmetic unit for the pipelined RV32IM core. Parametrised in datapath width, it implements the full RV32I ALU op set with a single-cycle registered result. It also implements the RV32M multiply/divide op set through an iterative shift-add / restoring-divide engine. A valid/ready handshake lets the hazard unit stall the pipeline while a multi-cycle M-op is in flight. It also produces registered compare flags for branch resolution.

---
 rtl/alu_pkg.sv | 64 ++++++
 rtl/mdu_iter.sv | 123 ++++++++++++
 rtl/alu_mdu.sv | 160 ++++++++++++++++
 tb/tb_alu_mdu.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag types for the execute-stage ALU/MDU.
package alu_pkg;

  localparam int unsigned OP_W = 5;

  // Bit 4 selects the M extension; bit 2 within the M space selects divide/remainder.
  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 5'h00,
    OP_SUB    = 5'h01,
    OP_AND    = 5'h02,
    OP_OR     = 5'h03,
    OP_XOR    = 5'h04,
    OP_SLL    = 5'h05,
    OP_SRL    = 5'h06,
    OP_SRA    = 5'h07,
    OP_SLT    = 5'h08,
    OP_SLTU   = 5'h09,
    OP_PASSB  = 5'h0A,
    OP_MUL    = 5'h10,
    OP_MULH   = 5'h11,
    OP_MULHSU = 5'h12,
    OP_MULHU  = 5'h13,
    OP_DIV    = 5'h14,
    OP_DIVU   = 5'h15,
    OP_REM    = 5'h16,
    OP_REMU   = 5'h17
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  // Compare flags reported alongside every result.
  typedef struct packed {
    logic eq;
    logic lt;
    logic ltu;
  } cmp_flags_t;

  // True for any multiply/divide opcode.
  function automatic logic is_mdu_op(input alu_op_e op);
    return op[4];
  endfunction

  // True for DIV/DIVU/REM/REMU.
  function automatic logic is_div_op(input alu_op_e op);
    return op[4] & op[2];
  endfunction

  // Operand A is treated as two's complement.
  function automatic logic op_a_signed(input alu_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Operand B is treated as two's complement.
  function automatic logic op_b_signed(input alu_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply (shift-add) and divide (restoring) datapath, one bit per step.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             step_i,
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_c_o,
  output logic [WIDTH-1:0] mul_res_c_o,
  output logic [WIDTH-1:0] div_res_c_o
);

  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam int unsigned PROD_W = 2 * WIDTH;

  alu_op_e          op_q, op_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;

  logic             a_sgn, b_sgn;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi, div_lo;

  logic [PROD_W-1:0] prod, prod_fix;
  logic [WIDTH-1:0]  quo_fix, rem_fix;

  // Convert operands to magnitudes; the signs are folded back in at the end.
  always_comb begin
    a_sgn = op_a_signed(op_i) & a_i[WIDTH-1];
    b_sgn = op_b_signed(op_i) & b_i[WIDTH-1];
    a_mag = a_sgn ? ({WIDTH{1'b0}} - a_i) : a_i;
    b_mag = b_sgn ? ({WIDTH{1'b0}} - b_i) : b_i;
  end

  // One step of each algorithm; {hi,lo} is product or {remainder,dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    mul_hi    = mul_sum[WIDTH:1];
    mul_lo    = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_hi    = div_ge ? WIDTH'(div_shift - {1'b0, opb_q}) : div_shift[WIDTH-1:0];
    div_lo    = {lo_q[WIDTH-2:0], div_ge};
  end

  // Load on start, otherwise advance one bit per step.
  always_comb begin
    op_d   = op_q;
    opb_d  = opb_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    cnt_d  = cnt_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    if (start_i) begin
      op_d   = op_i;
      opb_d  = b_mag;
      hi_d   = '0;
      lo_d   = a_mag;
      cnt_d  = '0;
      // A zero divisor keeps the all-ones quotient unnegated.
      neg_d  = (a_sgn ^ b_sgn) & (b_i != '0);
      rneg_d = a_sgn;
    end else if (step_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (op_q[2]) begin
        hi_d = div_hi;
        lo_d = div_lo;
      end else begin
        hi_d = mul_hi;
        lo_d = mul_lo;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_ADD;
      opb_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      opb_q  <= opb_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      cnt_q  <= cnt_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
    end
  end

  // Final results: multiply uses the last step's next value, divide the settled registers.
  always_comb begin
    last_c_o    = step_i && (cnt_q == CNT_W'(WIDTH - 1));
    prod        = {mul_hi, mul_lo};
    prod_fix    = neg_q ? ({PROD_W{1'b0}} - prod) : prod;
    mul_res_c_o = (op_q == OP_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[PROD_W-1:WIDTH];
    quo_fix     = neg_q  ? ({WIDTH{1'b0}} - lo_q) : lo_q;
    rem_fix     = rneg_q ? ({WIDTH{1'b0}} - hi_q) : hi_q;
    div_res_c_o = ((op_q == OP_REM) || (op_q == OP_REMU)) ? rem_fix : quo_fix;
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with iterative RV32M unit, valid/ready handshake and compare flags.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             eq_o,
  output logic             lt_o,
  output logic             ltu_o,
  output logic             busy_o
);

  mdu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  cmp_flags_t       flags_q, flags_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic             accept_c;
  cmp_flags_t       in_flags_c;
  logic [WIDTH-1:0] alu_res_c;
  logic [SHAMT_W-1:0] shamt_c;
  logic             mdu_start_c;
  logic             mdu_step_c;
  logic             mdu_last_c;
  logic [WIDTH-1:0] mdu_mul_res_c;
  logic [WIDTH-1:0] mdu_div_res_c;

  assign accept_c    = in_valid_i && ready_q && !flush_i;
  assign mdu_step_c  = (state_q == ST_MUL) || (state_q == ST_DIV);

  assign in_ready_o  = ready_q;
  assign busy_o      = busy_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign eq_o        = flags_q.eq;
  assign lt_o        = flags_q.lt;
  assign ltu_o       = flags_q.ltu;

  // Single-cycle ALU result and compare flags from the presented operands.
  always_comb begin
    in_flags_c.eq  = (a_i == b_i);
    in_flags_c.lt  = ($signed(a_i) < $signed(b_i));
    in_flags_c.ltu = (a_i < b_i);
    shamt_c        = b_i[SHAMT_W-1:0];
    alu_res_c      = '0;
    case (op_i)
      OP_ADD:   alu_res_c = a_i + b_i;
      OP_SUB:   alu_res_c = a_i - b_i;
      OP_AND:   alu_res_c = a_i & b_i;
      OP_OR:    alu_res_c = a_i | b_i;
      OP_XOR:   alu_res_c = a_i ^ b_i;
      OP_SLL:   alu_res_c = a_i << shamt_c;
      OP_SRL:   alu_res_c = a_i >> shamt_c;
      OP_SRA:   alu_res_c = $signed(a_i) >>> shamt_c;
      OP_SLT:   alu_res_c = WIDTH'(in_flags_c.lt);
      OP_SLTU:  alu_res_c = WIDTH'(in_flags_c.ltu);
      OP_PASSB: alu_res_c = b_i;
      default:  alu_res_c = '0;
    endcase
  end

  mdu_iter #(
    .WIDTH (WIDTH)
  ) u_mdu_iter (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (mdu_start_c),
    .step_i      (mdu_step_c),
    .op_i        (op_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .last_c_o    (mdu_last_c),
    .mul_res_c_o (mdu_mul_res_c),
    .div_res_c_o (mdu_div_res_c)
  );

  // Sequencing of ALU/MDU operations; flush aborts and drops any pending pulse.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    flags_d     = flags_q;
    mdu_start_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          flags_d = in_flags_c;
          if (is_mdu_op(op_i)) begin
            mdu_start_c = 1'b1;
            state_d     = is_div_op(op_i) ? ST_DIV : ST_MUL;
          end else begin
            result_d    = alu_res_c;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mdu_last_c) begin
          result_d    = mdu_mul_res_c;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DIV: begin
        if (mdu_last_c) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        result_d    = mdu_div_res_c;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) begin
      state_d     = ST_IDLE;
      result_d    = result_q;
      out_valid_d = 1'b0;
      flags_d     = flags_q;
      mdu_start_c = 1'b0;
    end
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      flags_q     <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      flags_q     <= flags_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: expected results queued at accept, checked on out_valid.
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid_i;
  logic         in_ready_o;
  alu_op_e      op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         flush_i;
  logic         out_valid_o;
  logic [W-1:0] result_o;
  logic         eq_o, lt_o, ltu_o;
  logic         busy_o;

  typedef struct {
    alu_op_e      op;
    logic [W-1:0] res;
    logic         eq;
    logic         lt;
    logic         ltu;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           last_accept = 0;
  logic [W-1:0] last_res = '0;

  alu_mdu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .result_o    (result_o),
    .eq_o        (eq_o),
    .lt_o        (lt_o),
    .ltu_o       (ltu_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference results computed with wide native arithmetic.
  function automatic logic [W-1:0] model(input alu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    logic [4:0]  sh;
    sh = b[4:0];
    case (op)
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_AND:    return a & b;
      OP_OR:     return a | b;
      OP_XOR:    return a ^ b;
      OP_SLL:    return a << sh;
      OP_SRL:    return a >> sh;
      OP_SRA:    return $signed(a) >>> sh;
      OP_SLT:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU:   return (a < b) ? 32'd1 : 32'd0;
      OP_PASSB:  return b;
      OP_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      OP_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      OP_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      OP_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      OP_REMU:   return (b == 32'd0) ? a : a % b;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic int lat(input alu_op_e op);
    if (!op[4]) return 1;
    return op[2] ? W + 2 : W + 1;
  endfunction

  function automatic logic [W-1:0] pick(input int k);
    case (k)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Compare every result pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid_o === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid cyc=%0d res=%h, want no pulse", cyc, result_o);
      end else begin
        exp_t    e;
        alu_op_e eop;
        e   = sb.pop_front();
        eop = e.op;
        if (result_o !== e.res || eq_o !== e.eq || lt_o !== e.lt || ltu_o !== e.ltu || cyc != e.due) begin
          errors++;
          $display("FAIL out_%s got res=%h eq=%b lt=%b ltu=%b cyc=%0d, want res=%h eq=%b lt=%b ltu=%b cyc=%0d",
                   eop.name(), result_o, eq_o, lt_o, ltu_o, cyc, e.res, e.eq, e.lt, e.ltu, e.due);
        end
        last_res = e.res;
      end
    end
  end

  // Present one op, holding valid until ready; queue the expectation if one is due.
  task automatic send(input alu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit exp_out, input bit fl);
    int   waited;
    exp_t e;
    @(negedge clk);
    in_valid_i = 1'b1;
    op_i       = op;
    a_i        = a;
    b_i        = b;
    flush_i    = fl;
    waited     = 0;
    while (in_ready_o !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout op=%s ready=%b want 1", op.name(), in_ready_o);
    end else begin
      last_accept = cyc;
      if (exp_out && !fl) begin
        e.op  = op;
        e.res = model(op, a, b);
        e.eq  = (a == b);
        e.lt  = ($signed(a) < $signed(b));
        e.ltu = (a < b);
        e.due = cyc + lat(op);
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid_i = 1'b0;
    op_i       = OP_ADD;
    a_i        = '0;
    b_i        = '0;
    flush_i    = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl got valid=%b busy=%b ready=%b want 0 0 1", out_valid_o, busy_o, in_ready_o);
    end
    checks++;
    if (result_o !== 32'd0 || {eq_o, lt_o, ltu_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_data got res=%h flags=%b want 0 000", result_o, {eq_o, lt_o, ltu_o});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || in_ready_o !== 1'b1 || result_o !== 32'd0) begin
      errors++;
      $display("FAIL after_reset got valid=%b busy=%b ready=%b res=%h want 0 0 1 0",
               out_valid_o, busy_o, in_ready_o, result_o);
    end
  endtask

  task automatic test_alu();
    int first;
    send(OP_ADD,  32'h7FFF_FFFF, 32'd1,         1, 0);
    send(OP_SRA,  32'h8000_0000, 32'd4,         1, 0);
    send(OP_SLTU, 32'd1,         32'hFFFF_FFFF, 1, 0);
    send(OP_SLL,  32'h0000_0001, 32'hFFFF_FFFF, 1, 0);
    send(OP_PASSB, 32'h1234_5678, 32'hABCD_E000, 1, 0);
    first = -1;
    for (int i = 0; i < 20; i++) begin
      alu_op_e      op;
      logic [W-1:0] a, b;
      op = alu_op_e'(5'($urandom_range(0, 10)));
      a  = pick($urandom_range(0, 7));
      b  = (i % 4 == 0) ? a : pick($urandom_range(0, 7));
      send(op, a, b, 1, 0);
      if (first < 0) first = last_accept;
    end
    checks++;
    if (last_accept - first != 19) begin
      errors++;
      $display("FAIL alu_back_to_back span=%0d want 19", last_accept - first);
    end
    drain();
    repeat (3) @(negedge clk);
    checks++;
    if (result_o !== last_res || out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL result_hold got res=%h valid=%b want %h 0", result_o, out_valid_o, last_res);
    end
  endtask

  task automatic test_mul();
    int bad;
    send(OP_MULH, 32'h8000_0000, 32'h8000_0000, 1, 0);
    bad = 0;
    for (int i = 1; i <= W + 1; i++) begin
      @(negedge clk);
      if (busy_o !== 1'b1 || in_ready_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mul_busy bad_cycles=%0d want 0", bad);
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL mul_release got busy=%b ready=%b want 0 1", busy_o, in_ready_o);
    end
    send(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    send(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    send(OP_MULHSU, 32'hFFFF_FFFE, 32'h0000_0003, 1, 0);
    send(OP_MULH,   32'hFFFF_FFF9, 32'h0000_0005, 1, 0);
    drain();
  endtask

  task automatic test_div();
    send(OP_DIV,  32'hFFFF_FFF9, 32'd2,         1, 0);
    send(OP_REM,  32'hFFFF_FFF9, 32'd2,         1, 0);
    send(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    send(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    send(OP_DIVU, 32'd7,         32'd0,         1, 0);
    send(OP_REMU, 32'd7,         32'd0,         1, 0);
    send(OP_DIV,  32'hFFFF_FFFB, 32'd0,         1, 0);
    send(OP_REM,  32'hFFFF_FFFB, 32'd0,         1, 0);
    send(OP_REM,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 1, 0);
    send(OP_DIVU, 32'hFFFF_FFFF, 32'd10,        1, 0);
    drain();
  endtask

  task automatic test_mdu_random();
    for (int i = 0; i < 12; i++) begin
      alu_op_e op;
      op = alu_op_e'(5'(16 + $urandom_range(0, 7)));
      send(op, pick($urandom_range(0, 7)), pick($urandom_range(0, 7)), 1, 0);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int n;
    send(OP_MUL, 32'd12345, 32'd678, 1, 0);
    n = last_accept;
    send(OP_ADD, 32'd40, 32'd2, 1, 0);
    checks++;
    if (last_accept != n + W + 2) begin
      errors++;
      $display("FAIL held_valid_accept got cyc=%0d want %0d", last_accept, n + W + 2);
    end
    send(OP_SUB, 32'd1, 32'd2, 1, 0);
    drain();
  endtask

  task automatic test_flush();
    int n, pulses;
    send(OP_DIV, 32'd100, 32'd7, 0, 0);
    n = last_accept;
    while (cyc < n + 10) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    checks++;
    if (in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready got ready=%b busy=%b want 1 0", in_ready_o, busy_o);
    end
    send(OP_ADD, 32'd5, 32'd6, 1, 0);
    checks++;
    if (last_accept != n + 11) begin
      errors++;
      $display("FAIL flush_add_accept got cyc=%0d want %0d", last_accept, n + 11);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL flush_pulses got %0d want 1", pulses);
    end
    drain();
  endtask

  task automatic test_flush_accept();
    send(OP_ADD, 32'd1, 32'd2, 0, 1);
    @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_alu_accept got valid=%b want 0", out_valid_o);
    end
    send(OP_MUL, 32'd3, 32'd4, 0, 1);
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_mul_accept got busy=%b ready=%b want 0 1", busy_o, in_ready_o);
    end
    repeat (W + 4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    send(OP_MUL, 32'd3, 32'd5, 0, 0);
    n = last_accept;
    while (cyc < n + 5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ctrl got valid=%b busy=%b ready=%b want 0 0 1", out_valid_o, busy_o, in_ready_o);
    end
    checks++;
    if (result_o !== 32'd0 || {eq_o, lt_o, ltu_o} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_data got res=%h flags=%b want 0 000", result_o, {eq_o, lt_o, ltu_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(OP_ADD, 32'd100, 32'd23, 1, 0);
    drain();
    repeat (W + 4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_mdu_random();
    test_back_to_back();
    test_flush();
    test_flush_accept();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d want completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
